// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-way memory arbiter.
// Holds bus widths, state encodings and the picker result type.
package mem_arbiter_pkg;

    localparam int NPC_ADDR_BUS = 32;
    localparam int XLEN_BUS     = 64;
    localparam int MASK_W       = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GRANT_I  = 3'd1;
    localparam logic [2:0] ST_GRANT_DR = 3'd2;
    localparam logic [2:0] ST_GRANT_DW = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        GRANT_I  = ST_GRANT_I,
        GRANT_DR = ST_GRANT_DR,
        GRANT_DW = ST_GRANT_DW,
        RESP     = ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        PICK_NONE = 2'd0,
        PICK_I    = 2'd1,
        PICK_DR   = 2'd2,
        PICK_DW   = 2'd3
    } pick_e;

    // Round-robin memory: which side won the previous grant.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    function automatic state_e grant_state(input pick_e p);
        case (p)
            PICK_I:  return GRANT_I;
            PICK_DR: return GRANT_DR;
            PICK_DW: return GRANT_DW;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single memory port bundle between the arbiter and the memory.
// master: arbiter side (drives request), slave: memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_mask_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_valid_o;
    logic              mem_write_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_addr_o,
        output mem_mask_o,
        output mem_wdata_o,
        output mem_valid_o,
        output mem_write_o,
        input  mem_ready_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_mask_o,
        input  mem_wdata_o,
        input  mem_valid_o,
        input  mem_write_o,
        output mem_ready_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational request picker for the memory arbiter.
// Ports: req_i_i/req_dr_i/req_dw_i requests, last_grant_i, pick_o winner.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic  req_i_i,
    input  logic  req_dr_i,
    input  logic  req_dw_i,
    input  logic  last_grant_i,
    output pick_e pick_o
);

    logic req_d;

    assign req_d = req_dr_i | req_dw_i;

    // The dcache side wins when alone or when icache had the last turn;
    // within dcache a write always beats a read.
    always_comb begin
        pick_o = PICK_NONE;
        if (req_d && (!req_i_i || last_grant_i == LAST_I)) begin
            pick_o = req_dw_i ? PICK_DW : PICK_DR;
        end else if (req_i_i) begin
            pick_o = PICK_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache read, dcache read and dcache write onto one memory
// port. Ports: clk, rst, per-requester request/ready/data, mem bundle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = NPC_ADDR_BUS,
    parameter int DATA_W = XLEN_BUS
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ram_raddr_icache_i,
    input  logic              ram_raddr_valid_icache_i,
    input  logic [7:0]        ram_rmask_icache_i,
    output logic              ram_rdata_ready_icache_o,
    output logic [DATA_W-1:0] ram_rdata_icache_o,

    input  logic [ADDR_W-1:0] ram_raddr_dcache_i,
    input  logic              ram_raddr_valid_dcache_i,
    input  logic [7:0]        ram_rmask_dcache_i,
    output logic              ram_rdata_ready_dcache_o,
    output logic [DATA_W-1:0] ram_rdata_dcache_o,

    input  logic [ADDR_W-1:0] ram_waddr_dcache_i,
    input  logic              ram_waddr_valid_dcache_i,
    input  logic [7:0]        ram_wmask_dcache_i,
    input  logic [DATA_W-1:0] ram_wdata_dcache_i,
    output logic              ram_wdata_ready_dcache_o,

    mem_arbiter_if.master     mem
);

    state_e            state_q, state_d;
    pick_e             gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        mask_q, mask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_i_q, rdata_i_d;
    logic [DATA_W-1:0] rdata_d_q, rdata_d_d;

    pick_e             pick;

    mem_arb_pick u_pick (
        .req_i_i      (ram_raddr_valid_icache_i),
        .req_dr_i     (ram_raddr_valid_dcache_i),
        .req_dw_i     (ram_waddr_valid_dcache_i),
        .last_grant_i (last_q),
        .pick_o       (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= PICK_NONE;
            last_q    <= LAST_I;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            write_q   <= FALSE;
            valid_q   <= FALSE;
            rdata_i_q <= '0;
            rdata_d_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            valid_q   <= valid_d;
            rdata_i_q <= rdata_i_d;
            rdata_d_q <= rdata_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        valid_d   = valid_q;
        rdata_i_d = rdata_i_q;
        rdata_d_d = rdata_d_q;

        unique case (state_q)
            IDLE: begin
                if (pick != PICK_NONE) begin
                    state_d = grant_state(pick);
                    gnt_d   = pick;
                    valid_d = TRUE;
                    last_d  = (pick == PICK_I) ? LAST_I : LAST_D;
                    unique case (pick)
                        PICK_I: begin
                            addr_d  = ram_raddr_icache_i;
                            mask_d  = ram_rmask_icache_i;
                            wdata_d = '0;
                            write_d = FALSE;
                        end
                        PICK_DR: begin
                            addr_d  = ram_raddr_dcache_i;
                            mask_d  = ram_rmask_dcache_i;
                            wdata_d = '0;
                            write_d = FALSE;
                        end
                        PICK_DW: begin
                            addr_d  = ram_waddr_dcache_i;
                            mask_d  = ram_wmask_dcache_i;
                            wdata_d = ram_wdata_dcache_i;
                            write_d = TRUE;
                        end
                        default: ;
                    endcase
                end
            end
            GRANT_I, GRANT_DR, GRANT_DW: begin
                // Ready in the very first valid cycle also completes.
                if (mem.mem_ready_i) begin
                    state_d = RESP;
                    valid_d = FALSE;
                    if (state_q == GRANT_I) begin
                        rdata_i_d = mem.mem_rdata_i;
                    end
                    if (state_q == GRANT_DR) begin
                        rdata_d_d = mem.mem_rdata_i;
                    end
                end
            end
            // One-cycle pulse; IDLE is not evaluated here, so a held
            // valid is re-arbitrated only in the following cycle.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_mask_o  = mask_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_valid_o = valid_q;
    assign mem.mem_write_o = write_q;

    assign ram_rdata_ready_icache_o = (state_q == RESP) && (gnt_q == PICK_I);
    assign ram_rdata_ready_dcache_o = (state_q == RESP) && (gnt_q == PICK_DR);
    assign ram_wdata_ready_dcache_o = (state_q == RESP) && (gnt_q == PICK_DW);

    assign ram_rdata_icache_o = rdata_i_q;
    assign ram_rdata_dcache_o = rdata_d_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width; it matches `NPC_ADDR_BUS.
REQ-002 SHALL have parameter DATA_W, default 64, data width; it matches `XLEN_BUS.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named as below.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset.
REQ-006 ram_raddr_icache_i  in  ADDR_W  icache read address.
REQ-007 ram_raddr_valid_icache_i  in  1  icache read request, held until its ready.
REQ-008 ram_rmask_icache_i  in  8  icache byte mask.
REQ-009 ram_rdata_ready_icache_o  out  1  one-cycle completion pulse to icache.
REQ-010 ram_rdata_icache_o  out  DATA_W  icache read data, valid with its ready.
REQ-011 ram_raddr_dcache_i / ram_raddr_valid_dcache_i / ram_rmask_dcache_i  in  ADDR_W/1/8  dcache read request.
REQ-012 ram_rdata_ready_dcache_o / ram_rdata_dcache_o  out  1/DATA_W  dcache read completion pulse and data.
REQ-013 ram_waddr_dcache_i / ram_waddr_valid_dcache_i / ram_wmask_dcache_i / ram_wdata_dcache_i  in  ADDR_W/1/8/DATA_W  dcache write request.
REQ-014 ram_wdata_ready_dcache_o  out  1  one-cycle dcache write completion pulse.
REQ-015 mem_addr_o / mem_mask_o / mem_wdata_o  out  ADDR_W/8/DATA_W  single memory port request fields.
REQ-016 mem_valid_o / mem_write_o  out  1/1  request valid; 1 = write, 0 = read.
REQ-017 mem_ready_i / mem_rdata_i  in  1/DATA_W  memory completion (one cycle) and read data.

Function
REQ-018 SHALL implement an FSM with states IDLE, GRANT_I, GRANT_DR, GRANT_DW, RESP.
REQ-019 In IDLE, arbitration SHALL follow this rule: dcache write beats dcache read; the dcache group and icache alternate round-robin using a 1-bit last_grant register; a lone requester wins immediately.
REQ-020 On a grant, addr, mask, wdata and the write flag SHALL be latched into registers; mem_valid_o SHALL rise in the next cycle.
REQ-021 mem_* outputs SHALL be driven only from the latched registers; requester inputs changing after the grant SHALL have no effect.
REQ-022 mem_valid_o SHALL stay high until the cycle in which mem_ready_i is 1; mem_ready_i already high in the first valid cycle SHALL count as completion.
REQ-023 On completion, mem_rdata_i SHALL be registered, the FSM SHALL enter RESP, and mem_valid_o SHALL fall in the next cycle.
REQ-024 In RESP, exactly one ready output (that of the granted requester) SHALL be 1 for exactly one cycle, with the registered data on its rdata output; the FSM then returns to IDLE.
REQ-025 IDLE SHALL never sample requests in the cycle in which a ready pulse is high, so a requester that keeps valid high with a new address (back-to-back cache-line beats) is re-arbitrated as a new request.
REQ-026 Latency: request seen in IDLE at cycle N, mem_ready_i at cycle N+1+k (k>=0) -> ready pulse at cycle N+2+k.
REQ-027 Read-data outputs SHALL hold their last value when not pulsed; non-granted ready outputs SHALL be 0.
REQ-028 mem_mask_o SHALL be passed through unmodified; the arbiter performs no alignment.

Reset
REQ-029 rst SHALL force: FSM=IDLE, last_grant=icache (so dcache wins the first tie), mem_valid_o=0, mem_write_o=0, all ready outputs=0, all registered data/address/mask=0.
REQ-030 rst asserted mid-transaction SHALL abandon the transaction without issuing a ready pulse; the memory model is reset together with the arbiter.

Structure
REQ-031 `NPC_ADDR_BUS, `XLEN_BUS, `TRUE and `FALSE SHALL come from sysconfig.v; the state encodings SHALL be localparams.
REQ-032 A single sub-module, mem_arb_pick (combinational round-robin/priority picker), SHALL be used.

Verification
REQ-033 icache read only, addr 0x8000_0000, mem_ready_i after 3 cycles, rdata 0x1122334455667788 -> icache ready pulse for one cycle carrying that data; dcache readies stay 0.
REQ-034 icache read and dcache read asserted in the same cycle after reset -> dcache served first, icache served next; with both still requesting, grants alternate.
REQ-035 dcache read and write asserted together, waddr 0x8000_0010, wmask 0xFF -> write issued first with mem_write_o=1 and the correct wdata/mask; the read follows.
REQ-036 dcache holds valid and changes address 0x..00 -> 0x..08 across two beats -> two separate memory reads with the correct addresses, with no icache starvation when icache is pending.
REQ-037 mem_ready_i high in the first valid cycle -> ready pulse exactly 2 cycles after the request; rst during GRANT_DR -> no ready pulse, mem_valid_o=0 next cycle.
